// File: rtl/write_scoreboard_pkg.sv
// write_scoreboard_pkg: shared register, write-descriptor and counter types for the write scoreboard
package write_scoreboard_pkg;
    localparam int SB_CNT_W = 3;
    typedef logic [4:0] creg_addr_t;
    typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_MEM = 2'd1, SRC_IMM = 2'd2, SRC_PC = 2'd3} src_t;
    typedef struct packed {
        logic       valid;
        src_t       src;
        logic [31:0] value;
        creg_addr_t dst;
    } write_reg_t;
    typedef logic [SB_CNT_W-1:0] sb_cnt_t;
endpackage

// File: rtl/write_sb_counter.sv
// write_sb_counter: one register's outstanding-write counter with net delta, plus its load-pending flag
// Ports: clk, reset (async), flush; acc = bundle accepted; inc/dec = same-cycle issues/writebacks;
//        mem = youngest issue to this register is a load; busy, mem_pending; overflow (would exceed max
//        if accepted), underflow (writeback below zero this cycle).
module write_sb_counter #(
    parameter int CNT_W = 3,
    parameter int DW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          acc,
    input  logic [DW-1:0] inc,
    input  logic [DW-1:0] dec,
    input  logic          mem,
    output logic          busy,
    output logic          mem_pending,
    output logic          overflow,
    output logic          underflow
);
    localparam int SW = CNT_W + DW + 1;
    localparam logic signed [SW-1:0] MAX = SW'((1 << CNT_W) - 1);
    logic [CNT_W-1:0] count;
    logic signed [SW-1:0] c_s, i_s, d_s, a_s, tot, nxt;
    always_comb begin
        c_s = SW'(count);
        i_s = SW'(inc);
        d_s = SW'(dec);
        a_s = acc ? i_s : '0;
        tot = c_s + i_s - d_s;
        nxt = c_s + a_s - d_s;
    end
    // overflow uses the would-be issues so it can gate acceptance of the bundle
    assign overflow  = tot > MAX;
    assign underflow = nxt[SW-1] & ~flush;
    assign busy      = count != '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            mem_pending <= 1'b0;
        end else if (flush) begin
            count       <= '0;
            mem_pending <= 1'b0;
        end else begin
            count       <= nxt[SW-1] ? '0 : nxt[CNT_W-1:0];
            mem_pending <= (nxt[SW-1] || nxt == '0) ? 1'b0 : (acc && inc != '0) ? mem : mem_pending;
        end
    end
endmodule

// File: rtl/write_scoreboard.sv
// write_scoreboard: tracks outstanding register writes and stalls issue bundles on RAW hazards
// Ports: clk, reset (async); flush; issue_valid/issue_wr/issue_rs/issue_rt per lane (lane 0 oldest);
//        issue_ready (whole bundle accepted); wb_valid/wb_dst per writeback port; busy, mem_pending
//        per register; err_underflow (sticky).
module write_scoreboard
    import write_scoreboard_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int WB_WIDTH    = 2,
    parameter int CNT_W       = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [ISSUE_WIDTH-1:0]       issue_valid,
    input  write_reg_t [ISSUE_WIDTH-1:0] issue_wr,
    input  creg_addr_t [ISSUE_WIDTH-1:0] issue_rs,
    input  creg_addr_t [ISSUE_WIDTH-1:0] issue_rt,
    output logic                         issue_ready,
    input  logic [WB_WIDTH-1:0]          wb_valid,
    input  creg_addr_t [WB_WIDTH-1:0]    wb_dst,
    output logic [31:0]                  busy,
    output logic [31:0]                  mem_pending,
    output logic                         err_underflow
);
    localparam int MW = ISSUE_WIDTH > WB_WIDTH ? ISSUE_WIDTH : WB_WIDTH;
    localparam int DW = $clog2(MW + 1);
    logic [ISSUE_WIDTH-1:0] trk;
    logic hazard, accept, unused_value;
    logic [DW-1:0] inc [32];
    logic [DW-1:0] dec [32];
    logic [31:0] mem_y, ovf, uf;
    // busy[0] is constant 0, so register 0 sources never hazard; tracked dsts are nonzero
    always_comb begin
        hazard       = 1'b0;
        unused_value = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            trk[i]       = issue_valid[i] && issue_wr[i].valid && issue_wr[i].dst != '0;
            unused_value = unused_value ^ (^issue_wr[i].value);
        end
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            hazard = hazard | (issue_valid[i] && (busy[issue_rs[i]] || busy[issue_rt[i]]));
            for (int j = 0; j < i; j++)
                hazard = hazard | (issue_valid[i] && trk[j] &&
                         (issue_rs[i] == issue_wr[j].dst || issue_rt[i] == issue_wr[j].dst));
        end
    end
    // later lanes overwrite mem_y so the youngest write to a register decides its load flag
    always_comb begin
        mem_y = '0;
        for (int r = 0; r < 32; r++) begin
            inc[r] = '0;
            dec[r] = '0;
        end
        for (int i = 0; i < ISSUE_WIDTH; i++)
            if (trk[i]) begin
                inc[issue_wr[i].dst]   = inc[issue_wr[i].dst] + DW'(1);
                mem_y[issue_wr[i].dst] = issue_wr[i].src == SRC_MEM;
            end
        for (int w = 0; w < WB_WIDTH; w++)
            if (wb_valid[w] && wb_dst[w] != '0)
                dec[wb_dst[w]] = dec[wb_dst[w]] + DW'(1);
    end
    assign issue_ready = ~reset & ~hazard & ~|ovf & ~flush;
    assign accept      = issue_ready & |issue_valid;
    assign busy[0]        = 1'b0;
    assign mem_pending[0] = 1'b0;
    assign ovf[0]         = 1'b0;
    assign uf[0]          = 1'b0;
    for (genvar r = 1; r < 32; r++) begin : g_cnt
        write_sb_counter #(.CNT_W(CNT_W), .DW(DW)) u_cnt (
            .clk(clk), .reset(reset), .flush(flush), .acc(accept),
            .inc(inc[r]), .dec(dec[r]), .mem(mem_y[r]),
            .busy(busy[r]), .mem_pending(mem_pending[r]),
            .overflow(ovf[r]), .underflow(uf[r])
        );
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_underflow <= 1'b0;
        else if (|uf) err_underflow <= 1'b1;
    end
endmodule

// File: tb/tb_write_scoreboard.sv
// tb_write_scoreboard: directed self-checking bench for write_scoreboard (CNT_W=2 to reach saturation)
module tb_write_scoreboard;
    import write_scoreboard_pkg::*;
    logic clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic [1:0] issue_valid, wb_valid;
    write_reg_t [1:0] issue_wr;
    creg_addr_t [1:0] issue_rs, issue_rt, wb_dst;
    logic issue_ready, err_underflow;
    logic [31:0] busy, mem_pending;
    int tests = 0, failed = 0;

    always #5 clk = ~clk;

    write_scoreboard #(.ISSUE_WIDTH(2), .WB_WIDTH(2), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_dst(wb_dst),
        .busy(busy), .mem_pending(mem_pending), .err_underflow(err_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        issue_valid = '0; issue_wr = '0; issue_rs = '0; issue_rt = '0;
        wb_valid = '0; wb_dst = '0; flush = 1'b0;
    endtask

    task automatic lane(input int i, input logic v, input src_t s, input int dst, input int rs, input int rt);
        issue_valid[i] = 1'b1;
        issue_wr[i]    = '{valid: v, src: s, value: 32'h0, dst: 5'(dst)};
        issue_rs[i]    = 5'(rs);
        issue_rt[i]    = 5'(rt);
    endtask

    task automatic wb(input int p, input int dst);
        wb_valid[p] = 1'b1;
        wb_dst[p]   = 5'(dst);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1 clr();
        #1;
    endtask

    initial begin
        clr();
        lane(0, 1, SRC_ALU, 8, 0, 0);
        #2;
        chk("reset_ready", 32'(issue_ready), 32'h0);
        chk("reset_busy", busy, 32'h0);
        chk("reset_mem", mem_pending, 32'h0);
        chk("reset_err", 32'(err_underflow), 32'h0);
        cyc();
        reset = 1'b0;
        // older-lane dst hazard, then lane 0 alone
        lane(0, 1, SRC_ALU, 8, 0, 0);
        lane(1, 0, SRC_ALU, 0, 8, 0);
        #1 chk("lane_dst_hazard", 32'(issue_ready), 32'h0);
        issue_valid[1] = 1'b0;
        #1 chk("ready_after_reset", 32'(issue_ready), 32'h1);
        cyc();
        chk("busy8", busy, 32'h0000_0100);
        chk("mem8", mem_pending, 32'h0);
        wb(0, 8);
        cyc();
        chk("busy8_clear", busy, 32'h0);
        // load: pending for two cycles, then retired
        lane(0, 1, SRC_MEM, 9, 0, 0);
        cyc();
        chk("mem9_c1", mem_pending, 32'h0000_0200);
        cyc();
        chk("mem9_c2", mem_pending, 32'h0000_0200);
        wb(0, 9);
        cyc();
        chk("busy9_clear", busy, 32'h0);
        chk("mem9_clear", mem_pending, 32'h0);
        // saturation at count 3
        repeat (3) begin
            lane(0, 1, SRC_ALU, 5, 0, 0);
            cyc();
        end
        lane(0, 1, SRC_ALU, 5, 0, 0);
        #1 chk("sat_block", 32'(issue_ready), 32'h0);
        wb(0, 5);
        #1 chk("sat_wb_accept", 32'(issue_ready), 32'h1);
        cyc();
        wb(0, 5); wb(1, 5);
        cyc();
        chk("sat_count_was3", busy, 32'h0000_0020);
        wb(0, 5);
        cyc();
        chk("sat_drained", busy, 32'h0);
        // two lanes same dst count +2
        lane(0, 1, SRC_ALU, 5, 0, 0);
        lane(1, 1, SRC_ALU, 5, 0, 0);
        #1 chk("pair_ready", 32'(issue_ready), 32'h1);
        cyc();
        wb(0, 5);
        cyc();
        chk("pair_plus2", busy, 32'h0000_0020);
        wb(0, 5);
        cyc();
        chk("pair_drained", busy, 32'h0);
        // same-cycle accept and writeback net to zero change
        lane(0, 1, SRC_ALU, 3, 0, 0);
        cyc();
        lane(0, 1, SRC_ALU, 3, 0, 0);
        wb(0, 3);
        #1 chk("net_ready", 32'(issue_ready), 32'h1);
        cyc();
        chk("net_busy3", busy, 32'h0000_0008);
        wb(0, 3);
        cyc();
        chk("net_count1", busy, 32'h0);
        chk("no_underflow", 32'(err_underflow), 32'h0);
        // youngest lane decides load flag
        lane(0, 1, SRC_MEM, 10, 0, 0);
        lane(1, 1, SRC_ALU, 10, 0, 0);
        cyc();
        chk("young_alu_mem", mem_pending, 32'h0);
        chk("young_busy", busy, 32'h0000_0400);
        lane(0, 1, SRC_ALU, 10, 0, 0);
        lane(1, 1, SRC_MEM, 10, 0, 0);
        #1 chk("pair_overflow", 32'(issue_ready), 32'h0);
        issue_valid[0] = 1'b0;
        cyc();
        chk("young_mem", mem_pending, 32'h0000_0400);
        flush = 1'b1;
        cyc();
        chk("flush10", busy, 32'h0);
        // flush with busy regs 4 and 7
        lane(0, 1, SRC_ALU, 4, 0, 0);
        lane(1, 1, SRC_MEM, 7, 0, 0);
        cyc();
        chk("busy_4_7", busy, 32'h0000_0090);
        chk("mem_7", mem_pending, 32'h0000_0080);
        lane(0, 0, SRC_ALU, 0, 0, 7);
        #1 chk("rt_busy_hazard", 32'(issue_ready), 32'h0);
        clr();
        lane(0, 1, SRC_ALU, 2, 0, 0);
        flush = 1'b1;
        #1 chk("flush_ready", 32'(issue_ready), 32'h0);
        cyc();
        chk("flush_busy", busy, 32'h0);
        chk("flush_mem", mem_pending, 32'h0);
        // register 0 never tracked, wb to 0 ignored
        lane(0, 1, SRC_MEM, 0, 0, 0);
        lane(1, 1, SRC_ALU, 6, 0, 0);
        wb(0, 0);
        #1 chk("reg0_ready", 32'(issue_ready), 32'h1);
        cyc();
        chk("reg0_busy", busy, 32'h0000_0040);
        chk("reg0_err", 32'(err_underflow), 32'h0);
        wb(0, 6);
        cyc();
        // underflow is sticky through flush, cleared by reset
        wb(0, 12);
        cyc();
        chk("underflow_set", 32'(err_underflow), 32'h1);
        chk("underflow_busy", busy, 32'h0);
        flush = 1'b1;
        cyc();
        chk("underflow_flush", 32'(err_underflow), 32'h1);
        reset = 1'b1;
        #1 chk("underflow_reset", 32'(err_underflow), 32'h0);
        chk("reset_ready2", 32'(issue_ready), 32'h0);
        reset = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/write_scoreboard.md
WRITE_SCOREBOARD -- requirements
Module: write_scoreboard

Interface
REQ-001 The block SHALL have parameter ISSUE_WIDTH, default 2, meaning the number of decode lanes presented per cycle.
REQ-002 The block SHALL have parameter WB_WIDTH, default 2, meaning the number of writeback ports per cycle.
REQ-003 The block SHALL have parameter CNT_W, default 3, meaning the width of each per-register outstanding-write counter (max 2^CNT_W-1).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port flush, input, 1, which discards all in-flight write tracking.
REQ-007 The block SHALL have port issue_valid, input, ISSUE_WIDTH, the per-lane instruction-present flags; lane 0 is oldest.
REQ-008 The block SHALL have port issue_wr, input, ISSUE_WIDTH x write_reg_t, the decoded {valid, src, value, dst} per lane.
REQ-009 The block SHALL have port issue_rs, input, ISSUE_WIDTH x creg_addr_t, the first source register per lane.
REQ-010 The block SHALL have port issue_rt, input, ISSUE_WIDTH x creg_addr_t, the second source register per lane.
REQ-011 The block SHALL have port issue_ready, output, 1, meaning the whole issue bundle is accepted this cycle.
REQ-012 The block SHALL have port wb_valid, input, WB_WIDTH, the per-port writeback flags.
REQ-013 The block SHALL have port wb_dst, input, WB_WIDTH x creg_addr_t, the per-port writeback destination.
REQ-014 The block SHALL have port busy, output, 32, set where a register's count is nonzero.
REQ-015 The block SHALL have port mem_pending, output, 32, set where a register's most recent outstanding write is sourced from SRC_MEM.
REQ-016 The block SHALL have port err_underflow, output, 1, a sticky flag for a writeback to a register whose count is 0.

Function
REQ-017 Lane i SHALL be tracked only if issue_valid[i] && issue_wr[i].valid && issue_wr[i].dst != 0; otherwise it is untracked.
REQ-018 Lane i SHALL raise a hazard if issue_rs[i] or issue_rt[i] (nonzero) has busy set, using registered state only, with no same-cycle writeback bypass.
REQ-019 Lane i SHALL also raise a hazard if its rs or rt (nonzero) equals the dst of any tracked older lane j<i.
REQ-020 The block SHALL raise an overflow if any register's count + its same-cycle tracked issues - its same-cycle writebacks exceeds 2^CNT_W-1.
REQ-021 issue_ready SHALL equal NOT(any valid lane hazard) AND NOT overflow AND NOT flush; it is all-or-nothing, combinational from issue inputs and state, and never depends on issue_valid of a later cycle.
REQ-022 On accept (issue_ready && any issue_valid), the count[dst] of each tracked lane SHALL increment by 1, so two lanes with the same dst give +2.
REQ-023 Each wb_valid port with wb_dst != 0 SHALL decrement count[wb_dst] by 1; a same-cycle accept and writeback to one register net together in a single update.
REQ-024 A writeback SHALL NOT take a count below 0; the count holds at 0 and err_underflow is set until reset.
REQ-025 mem_pending[r] SHALL be set when the youngest accepted tracked lane targeting r has src == SRC_MEM, cleared when it has another src, and cleared when count[r] reaches 0.
REQ-026 On flush, all counts and mem_pending SHALL clear at the next edge, and flush takes priority over same-cycle issue and writeback; err_underflow is unaffected.
REQ-027 Register 0 SHALL never be busy or mem_pending, and SHALL never hazard.
REQ-028 State updates SHALL have 1-cycle latency: busy and mem_pending reflect accepts and writebacks at the next edge.

Reset
REQ-029 While reset is high, all counts, busy, mem_pending and err_underflow SHALL be 0, and issue_ready SHALL be 0.
REQ-030 After reset deasserts, issue_ready SHALL be 1 for any non-hazard bundle on the first clock.

Structure
REQ-031 The shared package SHALL hold the typedef sb_cnt_t (logic [CNT_W-1:0]) together with the existing write_reg_t, src_t and creg_addr_t; no new src encodings are added.
REQ-032 Each register's saturating up/down counter with delta input SHALL be the sub-module write_sb_counter, instantiated 31 times (registers 1..31).

Verification
REQ-033 Issue lane0 ADDU dst=8 and lane1 rs=8 -> issue_ready=0; issue lane0 alone -> next cycle busy[8]=1, mem_pending[8]=0.
REQ-034 Issue LW dst=9 (SRC_MEM), then wb_dst=9 two cycles later -> mem_pending[9]=1 for 2 cycles, then busy[9]=0.
REQ-035 With CNT_W=2, issue dst=5 three times, then one more -> 4th bundle sees issue_ready=0; a same-cycle wb_dst=5 lets it accept with count staying 3.
REQ-036 Same-cycle accept dst=3 and wb_dst=3 with count 1 -> count remains 1 and busy[3]=1.
REQ-037 Busy on regs 4 and 7 plus flush asserted with a valid issue -> issue_ready=0, and next cycle busy=0.
REQ-038 wb_dst=12 with count 0 -> err_underflow=1 and stays 1 through flush, cleared only by reset.
